// File: rtl/vga_mon_pkg.sv
// Shared constants for the VGA timing monitor: lock FSM states, default
// 640x480@60 timing and sync polarity encodings.
package vga_mon_pkg;

    localparam int H_TOTAL_640 = 800;
    localparam int V_TOTAL_480 = 525;
    localparam int H_SYNC_640  = 96;
    localparam int V_SYNC_480  = 2;

    localparam int SYNC_ACTIVE_LOW  = 0;
    localparam int SYNC_ACTIVE_HIGH = 1;

    typedef logic [1:0] mon_state_t;

    localparam mon_state_t ST_SEARCH  = 2'd0;
    localparam mon_state_t ST_ACQUIRE = 2'd1;
    localparam mon_state_t ST_LOCKED  = 2'd2;

    localparam logic [15:0] MEAS_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == MEAS_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sync_period_meter.sv
// Measures the period and active width of one sync signal in units of
// 'tick' and reports period/width violations on the cycle they are seen.
module sync_period_meter
    import vga_mon_pkg::*;
#(
    parameter int EXP_PERIOD = H_TOTAL_640,
    parameter int EXP_WIDTH  = H_SYNC_640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        samp_en,
    input  logic        tick,
    input  logic        sync_act,
    input  logic        restart,
    output logic        lead_edge,
    output logic [15:0] period_last,
    output logic        err_period,
    output logic        err_width
);

    logic        prev_act;
    logic        measured;
    logic        trail_edge;
    logic [15:0] period_cnt;
    logic [15:0] width_cnt;

    assign lead_edge  = samp_en & sync_act & ~prev_act;
    assign trail_edge = samp_en & ~sync_act & prev_act;

    // The first edge after reset or a lock loss closes a partial period, so it is never judged.
    assign err_period = lead_edge & measured & (period_cnt != 16'(EXP_PERIOD));
    assign err_width  = trail_edge & (width_cnt != 16'(EXP_WIDTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_act    <= 1'b0;
            measured    <= 1'b0;
            period_cnt  <= '0;
            width_cnt   <= '0;
            period_last <= '0;
        end else begin
            if (samp_en) begin
                prev_act <= sync_act;
            end

            if (lead_edge) begin
                period_last <= period_cnt;
                period_cnt  <= tick ? 16'd1 : 16'd0;
            end else if (tick) begin
                period_cnt <= sat_inc16(period_cnt);
            end

            if (lead_edge) begin
                width_cnt <= tick ? 16'd1 : 16'd0;
            end else if (tick && sync_act) begin
                width_cnt <= sat_inc16(width_cnt);
            end

            if (restart) begin
                measured <= 1'b0;
            end else if (lead_edge) begin
                measured <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_monitor.sv
// In-system monitor for a VGA output stream: frame detection, colour-change
// counting, line/frame period and sync width checks, and a lock FSM.
module vga_timing_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_640,
    parameter int V_TOTAL     = V_TOTAL_480,
    parameter int H_SYNC      = H_SYNC_640,
    parameter int V_SYNC      = V_SYNC_480,
    parameter int SYNC_POL    = SYNC_ACTIVE_LOW,
    parameter int COLOR_W     = 4,
    parameter int CNT_W       = 20,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pix_en,
    input  logic                 vga_hsync,
    input  logic                 vga_vsync,
    input  logic [3*COLOR_W-1:0] vga_rgb,
    input  logic                 clr_err,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic [CNT_W-1:0]     color_changes,
    output logic [15:0]          line_len_last,
    output logic [15:0]          frame_len_last,
    output logic                 err_hperiod,
    output logic                 err_hwidth,
    output logic                 err_vperiod,
    output logic                 err_vwidth,
    output logic                 locked,
    output logic [7:0]           loss_count
);

    localparam logic             ACT_LEVEL   = (SYNC_POL == SYNC_ACTIVE_HIGH) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CC_MAX      = '1;
    localparam logic [7:0]       LOCK_TARGET = 8'(LOCK_FRAMES);

    logic hs_act;
    logic vs_act;
    logic h_lead;
    logic v_lead;
    logic h_err_period;
    logic h_err_width;
    logic v_err_period;
    logic v_err_width;
    logic new_err;
    logic restart;
    logic rgb_change;

    logic [3*COLOR_W-1:0] rgb_prev;
    logic [CNT_W-1:0]     cc_count;

    mon_state_t state;
    logic [7:0] clean_cnt;
    logic       frame_dirty;

    assign hs_act = (vga_hsync == ACT_LEVEL);
    assign vs_act = (vga_vsync == ACT_LEVEL);

    assign new_err = h_err_period | h_err_width | v_err_period | v_err_width;
    assign restart = (state == ST_LOCKED) & new_err;
    assign locked  = (state == ST_LOCKED);

    sync_period_meter #(
        .EXP_PERIOD (H_TOTAL),
        .EXP_WIDTH  (H_SYNC)
    ) u_hmeter (
        .clk         (clk),
        .reset_n     (reset_n),
        .samp_en     (pix_en),
        .tick        (pix_en),
        .sync_act    (hs_act),
        .restart     (restart),
        .lead_edge   (h_lead),
        .period_last (line_len_last),
        .err_period  (h_err_period),
        .err_width   (h_err_width)
    );

    // Vertical timing counts lines, so its tick is the hsync leading edge.
    sync_period_meter #(
        .EXP_PERIOD (V_TOTAL),
        .EXP_WIDTH  (V_SYNC)
    ) u_vmeter (
        .clk         (clk),
        .reset_n     (reset_n),
        .samp_en     (pix_en),
        .tick        (h_lead),
        .sync_act    (vs_act),
        .restart     (restart),
        .lead_edge   (v_lead),
        .period_last (frame_len_last),
        .err_period  (v_err_period),
        .err_width   (v_err_width)
    );

    assign rgb_change = pix_en & (vga_rgb != rgb_prev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done    <= 1'b0;
            frame_count   <= '0;
            rgb_prev      <= '0;
            cc_count      <= '0;
            color_changes <= '0;
        end else begin
            frame_done <= v_lead;
            if (v_lead) begin
                frame_count <= frame_count + 16'd1;
            end
            if (pix_en) begin
                rgb_prev <= vga_rgb;
            end
            // The pixel on the vsync edge belongs to the new frame's count.
            if (v_lead) begin
                color_changes <= cc_count;
                cc_count      <= rgb_change ? CNT_W'(1) : '0;
            end else if (rgb_change && (cc_count != CC_MAX)) begin
                cc_count <= cc_count + CNT_W'(1);
            end
        end
    end

    // A new violation outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_hperiod <= 1'b0;
            err_hwidth  <= 1'b0;
            err_vperiod <= 1'b0;
            err_vwidth  <= 1'b0;
        end else begin
            err_hperiod <= h_err_period | (err_hperiod & ~clr_err);
            err_hwidth  <= h_err_width  | (err_hwidth  & ~clr_err);
            err_vperiod <= v_err_period | (err_vperiod & ~clr_err);
            err_vwidth  <= v_err_width  | (err_vwidth  & ~clr_err);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SEARCH;
            clean_cnt   <= '0;
            frame_dirty <= 1'b0;
            loss_count  <= '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (v_lead) begin
                        state       <= ST_ACQUIRE;
                        clean_cnt   <= '0;
                        frame_dirty <= 1'b0;
                    end
                end
                ST_ACQUIRE: begin
                    if (v_lead) begin
                        frame_dirty <= 1'b0;
                        if (!frame_dirty && !new_err) begin
                            if (clean_cnt + 8'd1 >= LOCK_TARGET) begin
                                state     <= ST_LOCKED;
                                clean_cnt <= '0;
                            end else begin
                                clean_cnt <= clean_cnt + 8'd1;
                            end
                        end else begin
                            clean_cnt <= '0;
                        end
                    end else if (new_err) begin
                        clean_cnt   <= '0;
                        frame_dirty <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (new_err) begin
                        state <= ST_SEARCH;
                        if (loss_count != 8'hFF) begin
                            loss_count <= loss_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_SEARCH;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
Synthesizable, parametrised monitor that checks the VGA output stream of game_console in-system or in simulation. It generalises frame detection and colour-change counting to any timing and colour depth. It also measures line/frame periods and sync widths, flags violations, and tracks lock state via an FSM. It taps vga_hsync/vga_vsync/vga_r/g/b and is read by debug logic or a bench.

Parameters:
H_TOTAL, 800, pixels per line (hsync leading edge to next)
V_TOTAL, 525, lines per frame (hsync edges between vsync leading edges)
H_SYNC, 96, required hsync active width in pixels
V_SYNC, 2, required vsync active width in lines
SYNC_POL, 0, active level of both syncs (0 = active-low)
COLOR_W, 4, bits per colour channel
CNT_W, 20, width of colour-change counter
LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
clk  in  1  system clock (100 MHz)
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel-rate strobe; all sampling qualified by it
vga_hsync  in  1  horizontal sync under test
vga_vsync  in  1  vertical sync under test
vga_rgb  in  3*COLOR_W  {r,g,b} under test
clr_err  in  1  one-cycle pulse, clears sticky error flags
frame_done  out  1  one-clk pulse per vsync leading edge
frame_count  out  16  vsync leading edges since reset, wraps
color_changes  out  CNT_W  pixel-to-pixel colour changes in last complete frame
line_len_last  out  16  measured pixels of last line
frame_len_last  out  16  measured lines of last frame
err_hperiod, err_hwidth, err_vperiod, err_vwidth  out  1 each  sticky violation flags
locked  out  1  FSM in LOCKED
loss_count  out  8  LOCKED->SEARCH transitions, saturating at 255

Behaviour:
- Reset: all outputs 0; FSM SEARCH; counters 0. Reset mid-frame discards partial measurements and applies immediately.
- Sampling: on each pix_en cycle, register hs/vs/rgb. Active level = (sig == SYNC_POL). Leading edge = inactive->active between consecutive samples. Non-pix_en cycles hold all state.
- Horizontal: the pixel counter resets to 1 on an hsync edge and otherwise increments per pix_en, saturating at 0xFFFF. On an edge, latch prior count into line_len_last. If the value != H_TOTAL and the line is fully measured (not the first edge after reset/SEARCH), set err_hperiod. Active-width counter is compared to H_SYNC on the trailing edge; a mismatch sets err_hwidth.
- Vertical: identical rules, ticked by hsync leading edges instead of pix_en. An hsync edge coincident with a vsync edge counts toward the new frame. The line counter resets to 1 in that case, 0 otherwise. The latched frame_len excludes it. Compare to V_TOTAL / V_SYNC -> err_vperiod / err_vwidth.
- Colour: a change is counted when the sampled rgb != previous sampled rgb. Count saturates at all-ones. On a vsync edge, copy to color_changes and restart the count (including the edge pixel's comparison).
- Latency: every output reflecting an edge updates exactly one clk after the pix_en cycle that sampled it. frame_done is high for exactly that one clk.
- Errors: sticky until clr_err. If clr_err coincides with a new error, the error wins and stays set.
- FSM SEARCH -> ACQUIRE on the first vsync edge.
- FSM ACQUIRE: counts clean frames (no new error in the frame). A new error restarts the count at 0. On reaching LOCK_FRAMES, go to LOCKED.
- FSM LOCKED: any new error -> SEARCH, locked drops the next clk, loss_count++.
- frame_count wraps 0xFFFF -> 0 silently.

Decomposition:
- Package vga_mon_pkg: FSM state enum (SEARCH, ACQUIRE, LOCKED), default 640x480@60 timing constants, sync-polarity constants.
- Sub-module sync_period_meter (tick input, sync sample, expected period/width parameters; edge/period/width/error outputs), instantiated once for horizontal (tick = pix_en) and once for vertical (tick = hsync edge).

Test Plan:
- Reset: assert reset_n=0 mid-frame -> all outputs 0 within the same cycle, FSM in SEARCH.
- Clean timing: params H_TOTAL=10, V_TOTAL=6, H_SYNC=2, V_SYNC=1, LOCK_FRAMES=2, pix_en every 4th clk, ideal stimulus for 4 frames -> line_len_last=10, frame_len_last=6, no errors, locked rises after the 3rd vsync edge, frame_count=4.
- Period fault: one 11-pixel line in frame 5 while LOCKED -> err_hperiod=1, locked=0 one clk after that edge, loss_count=1, relock after 2 clean frames.
- Width fault: one 3-pixel hsync pulse -> err_hwidth=1. clr_err pulse -> cleared. clr_err in the same cycle as a new fault -> flag stays 1.
- Colour count: alternate rgb 12'h000/12'hFFF every pixel for one 60-pixel frame -> color_changes=59 (first pixel compared to reset value 0 counts 0). Constant colour frame -> 0.
- Saturation/wrap: CNT_W=4 with 20 changes -> color_changes=15. Preload frame_count=0xFFFF -> next frame gives 0.
